imm_gen_pipe: RTL
=================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; legal values are 32 and 64.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-003 and REQ-004.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous pipeline flush.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  block can accept an instruction.
REQ-008 in_instr  input  32  raw RV32/RV64 instruction word.
REQ-009 in_pc  input  XLEN  PC of in_instr.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_imm  output  XLEN  decoded, extended immediate.
REQ-013 out_fmt  output  6  one-hot format: [5]=SHAMT, [4]=I, [3]=S, [2]=B, [1]=U, [0]=J, or all-zero.
REQ-014 out_target  output  XLEN  in_pc + out_imm.
REQ-015 out_illegal  output  1  opcode is not recognised.

Function
REQ-016 Format decode SHALL use in_instr[6:0]:
- 0010011 with funct3 001 or 101: SHAMT.
- 0010011 otherwise: I.
- 0000011, 1100111, 0001111, 1110011: I.
- 0100011: S.
- 1100011: B.
- 0110111, 0010111: U.
- 1101111: J.
REQ-017 Opcode 0110011 SHALL give out_fmt 0, out_imm 0 and out_illegal 0; any other unlisted opcode SHALL give out_fmt 0, out_imm 0 and out_illegal 1.
REQ-018 The immediates SHALL be formed as follows:
- I: instr[31:20] sign-extended.
- S: {instr[31:25], instr[11:7]} sign-extended.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0} sign-extended.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0} sign-extended.
- U: {instr[31:12], 12'b0} sign-extended to XLEN.
REQ-019 The SHAMT immediate SHALL be zero-extended instr[24:20] when XLEN=32 and instr[25:20] when XLEN=64.
REQ-020 out_target SHALL be the sum modulo 2^XLEN; carry-out is discarded.
REQ-021 Buffering SHALL be a 2-entry skid FIFO whose decode results are registered at acceptance.
REQ-022 The FIFO SHALL have three states: EMPTY, ONE and TWO.
REQ-023 A push SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-024 The FIFO state SHALL advance as follows:
- EMPTY with push goes to ONE.
- ONE with push only goes to TWO.
- ONE with pop only goes to EMPTY.
- ONE with push and pop stays in ONE.
- TWO with pop goes to ONE.
REQ-025 in_ready SHALL equal (state != TWO), be driven from a register, and have no combinational path from out_ready.
REQ-026 out_valid SHALL equal (state != EMPTY), and the out_* data outputs SHALL always reflect the oldest entry.
REQ-027 Latency SHALL be one cycle: an instruction accepted at edge N is presented on the outputs after edge N.
REQ-028 Entries SHALL leave in strict FIFO order with no loss or duplication.
REQ-029 Head outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-030 flush=1 at an edge SHALL empty the FIFO and discard any push in that cycle; flush has priority over push and pop.
REQ-031 When out_valid=0, the out_* data outputs SHALL be 0.

Reset
REQ-032 While rst=1 the block SHALL immediately force state EMPTY, out_valid=0, in_ready=1, and out_imm, out_fmt, out_target and out_illegal to 0, regardless of clk.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries; the first push is accepted at the first rising edge after rst deasserts.

Configuration
REQ-034 The macro IMM_GEN_TARGET_EN SHALL control the PC-relative target adder.
REQ-035 With IMM_GEN_TARGET_EN defined, the in_pc value SHALL be stored per entry and out_target SHALL be computed as in REQ-014 and REQ-020.
REQ-036 Without IMM_GEN_TARGET_EN, no PC storage or adder SHALL exist: in_pc is ignored, out_target is constant 0, and all other behaviour is unchanged.

Verification
REQ-037 Push 0xFFF00093 (addi x1,x0,-1) with out_ready=1 -> the next cycle shows out_valid=1, out_imm=0xFFFFFFFF, out_fmt=010000.
REQ-038 Push 0x01F09093 (slli x1,x1,31) -> out_imm=0x0000001F, out_fmt=100000, out_illegal=0.
REQ-039 Push 0xFFDFF06F (jal x0,-4) with in_pc=0x100 -> out_imm=0xFFFFFFFC, out_fmt=000001, out_target=0x000000FC with the macro and 0 without it.
REQ-040 With out_ready=0, offer 3 instructions back-to-back -> 2 are accepted and in_ready=0; then raise out_ready -> outputs appear in push order, one per cycle.
REQ-041 In state TWO, drive flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed instruction never appears.
REQ-042 Assert rst between clock edges while in ONE -> out_valid=0 and out_imm=0 without a clock edge; push 0x00000013 after release -> out_fmt=010000, out_imm=0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate decoder feeding a 2-entry skid FIFO with a registered in_ready.
// Define IMM_GEN_TARGET_EN to store the PC per entry and drive out_target = pc + imm.
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifoState_e;

  localparam logic [5:0] FMT_SHAMT = 6'b100000;
  localparam logic [5:0] FMT_I     = 6'b010000;
  localparam logic [5:0] FMT_S     = 6'b001000;
  localparam logic [5:0] FMT_B     = 6'b000100;
  localparam logic [5:0] FMT_U     = 6'b000010;
  localparam logic [5:0] FMT_J     = 6'b000001;
  localparam logic       SHAMT_WIDE = (XLEN == 64);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     decImm32;
  logic [XLEN-1:0] decImm;
  logic [5:0]      decFmt;
  logic            decIllegal;

  fifoState_e      state_q, state_d;
  logic            inReady_q, inReady_d;
  logic [XLEN-1:0] headImm_q, headImm_d, tailImm_q, tailImm_d;
  logic [5:0]      headFmt_q, headFmt_d, tailFmt_q, tailFmt_d;
  logic            headIll_q, headIll_d, tailIll_q, tailIll_d;
  logic            push, pop;
  logic            loadHead, loadTail, shiftTail;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];

  // Every immediate fits in 32 signed bits, so decode at 32 and sign-extend once.
  always_comb begin
    decImm32   = '0;
    decFmt     = '0;
    decIllegal = 1'b0;
    case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          decFmt   = FMT_SHAMT;
          decImm32 = {26'b0, in_instr[25] & SHAMT_WIDE, in_instr[24:20]};
        end else begin
          decFmt   = FMT_I;
          decImm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        decFmt   = FMT_I;
        decImm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0100011: begin
        decFmt   = FMT_S;
        decImm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        decFmt   = FMT_B;
        decImm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        decFmt   = FMT_U;
        decImm32 = {in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        decFmt   = FMT_J;
        decImm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011: decIllegal = 1'b0;
      default:    decIllegal = 1'b1;
    endcase
  end

  if (XLEN > 32) begin : gSext
    assign decImm = {{(XLEN-32){decImm32[31]}}, decImm32};
  end else begin : gNoSext
    assign decImm = decImm32[XLEN-1:0];
  end

  assign push = in_valid & inReady_q;
  assign pop  = out_valid & out_ready;

  // Head always holds the oldest entry; tail is only occupied in TWO.
  always_comb begin
    state_d   = state_q;
    loadHead  = 1'b0;
    loadTail  = 1'b0;
    shiftTail = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d  = ONE;
          loadHead = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          loadHead = 1'b1;
        end else if (push) begin
          state_d  = TWO;
          loadTail = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d   = ONE;
          shiftTail = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d   = EMPTY;
      loadHead  = 1'b0;
      loadTail  = 1'b0;
      shiftTail = 1'b0;
    end
    inReady_d = (state_d != TWO);
  end

  always_comb begin
    headImm_d = headImm_q;
    headFmt_d = headFmt_q;
    headIll_d = headIll_q;
    tailImm_d = tailImm_q;
    tailFmt_d = tailFmt_q;
    tailIll_d = tailIll_q;
    if (loadHead) begin
      headImm_d = decImm;
      headFmt_d = decFmt;
      headIll_d = decIllegal;
    end else if (shiftTail) begin
      headImm_d = tailImm_q;
      headFmt_d = tailFmt_q;
      headIll_d = tailIll_q;
    end
    if (loadTail) begin
      tailImm_d = decImm;
      tailFmt_d = decFmt;
      tailIll_d = decIllegal;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= EMPTY;
      inReady_q <= 1'b1;
      headImm_q <= '0;
      headFmt_q <= '0;
      headIll_q <= 1'b0;
      tailImm_q <= '0;
      tailFmt_q <= '0;
      tailIll_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inReady_q <= inReady_d;
      headImm_q <= headImm_d;
      headFmt_q <= headFmt_d;
      headIll_q <= headIll_d;
      tailImm_q <= tailImm_d;
      tailFmt_q <= tailFmt_d;
      tailIll_q <= tailIll_d;
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = (state_q != EMPTY);
  assign out_imm     = out_valid ? headImm_q : '0;
  assign out_fmt     = out_valid ? headFmt_q : '0;
  assign out_illegal = out_valid ? headIll_q : 1'b0;

`ifdef IMM_GEN_TARGET_EN
  logic [XLEN-1:0] headPc_q, headPc_d, tailPc_q, tailPc_d;

  always_comb begin
    headPc_d = headPc_q;
    tailPc_d = tailPc_q;
    if (loadHead) begin
      headPc_d = in_pc;
    end else if (shiftTail) begin
      headPc_d = tailPc_q;
    end
    if (loadTail) begin
      tailPc_d = in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headPc_q <= '0;
      tailPc_q <= '0;
    end else begin
      headPc_q <= headPc_d;
      tailPc_q <= tailPc_d;
    end
  end

  // Adder sits after the head register so the decode path stays short.
  assign out_target = out_valid ? (headPc_q + headImm_q) : '0;
`else
  logic unusedPc;
  assign unusedPc   = ^in_pc;
  assign out_target = '0;
`endif

endmodule
